// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble scheduler for the D/E/M/W pipeline registers and the PC hold.
// It resolves data-memory waits, taken jumps, load-use interlocks and fetch misses, and counts stall cycles.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [4:0]       d_rs_i,
    input  logic [4:0]       d_rt_i,
    input  logic             d_use_rs_i,
    input  logic             d_use_rt_i,
    input  logic [4:0]       e_rn_i,
    input  logic             e_wreg_i,
    input  logic             e_m2reg_i,
    input  logic             m_do_jmp_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             imem_ready_i,
    output logic             f_stall_o,
    output logic             d_stall_o,
    output logic             d_bubble_o,
    output logic             e_stall_o,
    output logic             e_bubble_o,
    output logic             m_stall_o,
    output logic             m_bubble_o,
    output logic             w_bubble_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o
);
    localparam int WC_W = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, MEM_WAIT} state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  perf_q, perf_d;

    logic wait_last, mem_busy, load_use;

    // On the last wait cycle the access is abandoned, so the pipeline is released that same cycle.
    assign wait_last = (state_q == MEM_WAIT) && (wait_cnt_q == WC_LAST);
    assign mem_busy  = dmem_req_i && !dmem_ack_i && !wait_last;
    assign load_use  = e_wreg_i && e_m2reg_i && (e_rn_i != 5'd0) &&
                       ((d_use_rs_i && (d_rs_i == e_rn_i)) ||
                        (d_use_rt_i && (d_rt_i == e_rn_i)));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = IDLE;
                end else if (wait_last) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        f_stall_o  = 1'b0;
        d_stall_o  = 1'b0;
        d_bubble_o = 1'b0;
        e_stall_o  = 1'b0;
        e_bubble_o = 1'b0;
        m_stall_o  = 1'b0;
        m_bubble_o = 1'b0;
        w_bubble_o = 1'b0;
        if (!resetn_i) begin
            d_bubble_o = 1'b1;
            e_bubble_o = 1'b1;
            m_bubble_o = 1'b1;
            w_bubble_o = 1'b1;
        end else if (mem_busy) begin
            f_stall_o  = 1'b1;
            d_stall_o  = 1'b1;
            e_stall_o  = 1'b1;
            m_stall_o  = 1'b1;
            w_bubble_o = 1'b1;
        end else if (m_do_jmp_i) begin
            d_bubble_o = 1'b1;
            e_bubble_o = 1'b1;
            m_bubble_o = 1'b1;
        end else begin
            // A held D beats a fetch-miss bubble when both hazards are present.
            if (load_use) begin
                f_stall_o  = 1'b1;
                d_stall_o  = 1'b1;
                e_bubble_o = 1'b1;
            end
            if (!imem_ready_i) begin
                f_stall_o = 1'b1;
                if (!load_use) d_bubble_o = 1'b1;
            end
        end
    end

    assign perf_d = (f_stall_o && (perf_q != {CNT_W{1'b1}})) ? perf_q + CNT_W'(1) : perf_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            perf_q     <= perf_d;
        end
    end

    assign bus_err_o        = bus_err_q;
    assign perf_stall_cnt_o = perf_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its expected controls,
// and a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Expected control words: {f_stall,d_stall,d_bubble,e_stall,e_bubble,m_stall,m_bubble,w_bubble,bus_err}
    localparam logic [8:0] C_RST  = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_MEM  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_JMP  = 9'b0_0_1_0_1_0_1_0_0;
    localparam logic [8:0] C_LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] C_IF   = 9'b1_0_1_0_0_0_0_0_0;
    localparam logic [8:0] C_BERR = 9'b0_0_0_0_0_0_0_0_1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, e_rn = '0;
    logic d_use_rs = 1'b0, d_use_rt = 1'b0, e_wreg = 1'b0, e_m2reg = 1'b0;
    logic m_do_jmp = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0, imem_ready = 1'b1;
    logic f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_bubble, bus_err;
    logic [CNT_W-1:0] perf;

    typedef struct {
        string            tag;
        logic [8:0]       ctl;
        logic [CNT_W-1:0] perf;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] exp_perf = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .d_rs_i(d_rs), .d_rt_i(d_rt), .d_use_rs_i(d_use_rs), .d_use_rt_i(d_use_rt),
        .e_rn_i(e_rn), .e_wreg_i(e_wreg), .e_m2reg_i(e_m2reg),
        .m_do_jmp_i(m_do_jmp), .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .imem_ready_i(imem_ready),
        .f_stall_o(f_stall), .d_stall_o(d_stall), .d_bubble_o(d_bubble),
        .e_stall_o(e_stall), .e_bubble_o(e_bubble), .m_stall_o(m_stall),
        .m_bubble_o(m_bubble), .w_bubble_o(w_bubble), .bus_err_o(bus_err),
        .perf_stall_cnt_o(perf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // lu: 0 ALU op in E, 1 load r5 read as rs, 2 load r0, 3 load r7 read as rt, 4 load r7 not read
    task automatic step(input string tag, input logic rst_n, input logic req, input logic ack,
                        input logic jmp, input logic imr, input int lu, input logic [8:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        resetn = rst_n; dmem_req = req; dmem_ack = ack; m_do_jmp = jmp; imem_ready = imr;
        e_wreg = 1'b1; e_m2reg = (lu != 0);
        d_use_rs = 1'b0; d_use_rt = 1'b0; d_rs = 5'd1; d_rt = 5'd2;
        case (lu)
            0: begin e_rn = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1; end
            1: begin e_rn = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1; d_rt = 5'd3; d_use_rt = 1'b1; end
            2: begin e_rn = 5'd0; d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b1; d_use_rt = 1'b1; end
            3: begin e_rn = 5'd7; d_rs = 5'd7; d_rt = 5'd7; d_use_rt = 1'b1; end
            default: begin e_rn = 5'd7; d_rs = 5'd7; d_rt = 5'd7; end
        endcase
        e.tag = tag; e.ctl = exp; e.perf = exp_perf;
        sb.push_back(e);
        if (!rst_n) exp_perf = '0;
        else if (exp[8] && exp_perf != {CNT_W{1'b1}}) exp_perf = exp_perf + 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_ctl"}, 32'({f_stall, d_stall, d_bubble, e_stall, e_bubble,
                                      m_stall, m_bubble, w_bubble, bus_err}), 32'(e.ctl));
            chk({e.tag, "_perf"}, 32'(perf), 32'(e.perf));
        end
    end

    initial begin
        // reset, then idle
        step("rst0", 0, 0, 0, 0, 1, 0, C_RST);
        step("rst1", 0, 0, 0, 0, 1, 0, C_RST);
        step("idle0", 1, 0, 0, 0, 1, 0, C_NONE);
        step("idle1", 1, 0, 0, 0, 1, 0, C_NONE);
        // memory wait released in the ack cycle
        for (int i = 0; i < 3; i++) step("memwait", 1, 1, 0, 0, 1, 0, C_MEM);
        step("memack", 1, 1, 1, 0, 1, 0, C_NONE);
        step("memdone", 1, 0, 0, 0, 1, 0, C_NONE);
        // load-use variants and fetch miss
        step("lu_rs", 1, 0, 0, 0, 1, 1, C_LU);
        step("lu_after", 1, 0, 0, 0, 1, 0, C_NONE);
        step("lu_r0", 1, 0, 0, 0, 1, 2, C_NONE);
        step("lu_rt", 1, 0, 0, 0, 1, 3, C_LU);
        step("lu_unused", 1, 0, 0, 0, 1, 4, C_NONE);
        step("lu_if", 1, 0, 0, 0, 0, 1, C_LU);
        step("ifmiss", 1, 0, 0, 0, 0, 0, C_IF);
        // jump masked by memory wait, honoured on release
        step("jmp_mem0", 1, 1, 0, 1, 0, 1, C_MEM);
        step("jmp_mem1", 1, 1, 0, 1, 0, 1, C_MEM);
        step("jmp_rel", 1, 1, 1, 1, 0, 1, C_JMP);
        step("jmp_idle", 1, 0, 0, 0, 1, 0, C_NONE);
        // repeated timeouts, counter saturates
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3)               step("to_rel", 1, 1, 0, 0, 1, 0, C_NONE);
            else if (i > 0 && i % 4 == 0) step("to_reent", 1, 1, 0, 0, 1, 0, C_MEM | C_BERR);
            else                          step("to_wait", 1, 1, 0, 0, 1, 0, C_MEM);
        end
        step("to_err", 1, 0, 0, 0, 1, 0, C_BERR);
        step("to_quiet", 1, 0, 0, 0, 1, 0, C_NONE);
        // reset on the last wait cycle: no bus error afterwards
        for (int i = 0; i < 3; i++) step("rw_wait", 1, 1, 0, 0, 1, 0, C_MEM);
        step("rw_rst", 0, 1, 0, 0, 1, 0, C_RST);
        step("rw_ack", 1, 1, 1, 0, 1, 0, C_NONE);
        step("rw_idle", 1, 0, 0, 0, 1, 0, C_NONE);
        @(posedge clk);
        @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
